stack_pointer_p: RTL and testbench
==================================

# stack_pointer_p

Parametrised stack pointer for the CPU address path, generalising the fixed 16-bit stack pointer. It holds a WIDTH-bit pointer that can be loaded from the address bus, stepped up or down by a configurable STEP, or adjusted by a signed offset taken from the bus. It enforces an inclusive [LOW_BOUND, HIGH_BOUND] window with sticky overflow and underflow flags, and drives its value back onto the address bus through a registered, tri-stated output stage. It sits on abus alongside the program counter and the transfer registers.

## Interface
- WIDTH, 16, pointer and bus width.
- STEP, 1, increment/decrement amount; 1..2^(WIDTH-1).
- OFFS_WIDTH, 8, width of the signed offset taken from abus[OFFS_WIDTH-1:0]; less than or equal to WIDTH.
- RESET_VALUE, 0, pointer value after reset.
- LOW_BOUND, 0, lowest legal pointer value.
- HIGH_BOUND, 2^WIDTH-1, highest legal pointer value; must be at least LOW_BOUND.

- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- loadn  in  1  active-low; load the pointer from abus.
- addn  in  1  active-low; add the sign-extended abus[OFFS_WIDTH-1:0] to the pointer.
- cupn  in  1  active-low; count up by STEP.
- cdownn  in  1  active-low; count down by STEP.
- clrfn  in  1  active-low; clear ovf and unf.
- outn  in  1  active-low; drive the output register onto abus.
- abus  inout  WIDTH  shared address bus.
- sp  out  WIDTH  live pointer value, for debug and the flag logic.
- ovf  out  1  sticky: an operation was rejected for exceeding HIGH_BOUND.
- unf  out  1  sticky: an operation was rejected for going below LOW_BOUND.

## Operation
- Reset, synchronous, at a rising edge with reset=1:
  - sp becomes RESET_VALUE and the output register becomes RESET_VALUE.
  - ovf and unf become 0.
  - Reset overrides every control input, including an operation already in progress.
- Command priority each edge, with exactly one command taking effect:
  - loadn low: load.
  - otherwise addn low: add.
  - otherwise exactly one of cupn/cdownn low: step.
  - cupn and cdownn both low, with no load or add: hold, no flag change.
- Load: sp gets abus. The value is accepted unconditionally, even outside the bounds, and the flags are unchanged.
- Step up:
  - Compute sp+STEP in WIDTH+1 bits.
  - If the result is greater than HIGH_BOUND: sp is unchanged and ovf is set.
  - Otherwise sp takes the result.
- Step down:
  - If sp is less than LOW_BOUND+STEP, computed in WIDTH+1 bits: sp is unchanged and unf is set.
  - Otherwise sp becomes sp-STEP.
- Add:
  - Compute r = sp + sext(abus[OFFS_WIDTH-1:0]) as a signed value of WIDTH+2 bits.
  - If r is greater than HIGH_BOUND: hold and set ovf.
  - If r is less than LOW_BOUND: hold and set unf.
  - Otherwise sp takes r.
- There is no modular wrap-around. A rejected operation never changes sp.
- Flags are sticky until reset or clrfn.
  - If clrfn is low on the same edge that a rejection occurs, the set wins.
  - The other flag is still cleared on that edge.
- Output stage:
  - The output register captures sp on every rising edge.
  - abus equals the output register when outn=0, and is high-Z otherwise.
  - The bus is never driven combinationally from sp, so outn=0 together with loadn=0 is legal and reloads the registered value without a loop.

## Timing
- Every command takes effect at the first rising edge where it is sampled active. sp is valid right after that edge.
- The output register, and therefore abus, shows a new sp value one cycle after sp changes.
- Flag latency: ovf and unf are asserted immediately after the rejecting edge.
- abus is sampled at the rising edge for load and add. It must be stable during setup and hold around that edge.
- Tri-state enable is combinational from outn, with no clock latency. No bus contention arises from the block when outn=1.

## Test plan
- Reset with WIDTH=16 and RESET_VALUE=0xFFFE: sp=0xFFFE, abus Z with outn=1, ovf=0, unf=0. Then outn=0 gives abus=0xFFFE.
- Load and stepping, STEP=2:
  - Load 0x1234, then cdownn low for 3 cycles: sp reads 0x1232, 0x1230, 0x122E.
  - abus with outn low lags sp by 1 cycle.
- Bounds with LOW_BOUND=0x0100 and HIGH_BOUND=0x01FF:
  - At sp=0x01FF, cupn low gives sp=0x01FF and ovf=1.
  - At sp=0x0100, cdownn low gives unf=1.
  - clrfn low then clears both flags.
- Signed add, OFFS_WIDTH=8:
  - sp=0x2000 with abus[7:0]=0xF0 gives sp=0x1FF0.
  - A subsequent add of 0x7F gives sp=0x206F.
- Priority:
  - loadn, addn and cupn all low with abus=0x4000: sp=0x4000.
  - cupn and cdownn both low: sp unchanged.
  - A rejection with clrfn low on the same edge: the flag stays 1.
- Mid-operation reset: assert reset while cupn is held low. sp=RESET_VALUE on that edge, then counting resumes on the following edge after reset is released.

Source files
------------

// File: rtl/stack_pointer_p.sv
// stack_pointer_p
//   Parametrised CPU stack pointer on the shared address bus.
//   Each rising edge applies at most one command, in priority order:
//   load from abus, add a sign-extended bus offset, or step up/down by STEP.
//   Any operation that would leave [LOW_BOUND, HIGH_BOUND] is rejected. A
//   rejected operation leaves the pointer unchanged and sets a sticky flag.
//   The pointer reaches abus only through a registered, tri-stated output.
//
// Ports
//   clk     sole clock, rising edge
//   reset   synchronous, active-high
//   loadn   active-low: sp <= abus (unconditional)
//   addn    active-low: sp <= sp + sext(abus[OFFS_WIDTH-1:0]) if in bounds
//   cupn    active-low: sp <= sp + STEP if in bounds
//   cdownn  active-low: sp <= sp - STEP if in bounds
//   clrfn   active-low: clear ovf/unf (a same-edge rejection still sets)
//   outn    active-low: drive the output register onto abus
//   abus    shared address bus (inout)
//   sp      live pointer value
//   ovf     sticky: an operation was rejected above HIGH_BOUND
//   unf     sticky: an operation was rejected below LOW_BOUND

module stack_pointer_p #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      STEP        = 1,
  parameter int unsigned      OFFS_WIDTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] LOW_BOUND   = '0,
  parameter logic [WIDTH-1:0] HIGH_BOUND  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loadn,
  input  logic             addn,
  input  logic             cupn,
  input  logic             cdownn,
  input  logic             clrfn,
  input  logic             outn,
  inout  wire  [WIDTH-1:0] abus,
  output logic [WIDTH-1:0] sp,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned     EXT_BITS = WIDTH + 2 - OFFS_WIDTH;
  localparam logic [WIDTH:0]  STEP_W   = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] sp_q, sp_next;
  logic [WIDTH-1:0] out_q;
  logic             ovf_q, ovf_next;
  logic             unf_q, unf_next;

  // Step arithmetic is done one bit wider so no result can wrap.
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] down_limit;

  // Add arithmetic: two extra bits give a sign bit plus carry headroom, so
  // both over- and under-range results compare correctly as signed values.
  logic signed [WIDTH+1:0] offs_ext;
  logic signed [WIDTH+1:0] add_r;
  logic signed [WIDTH+1:0] high_s;
  logic signed [WIDTH+1:0] low_s;

  always_comb begin
    up_sum     = {1'b0, sp_q} + STEP_W;
    down_limit = {1'b0, LOW_BOUND} + STEP_W;
    offs_ext   = {{EXT_BITS{abus[OFFS_WIDTH-1]}}, abus[OFFS_WIDTH-1:0]};
    add_r      = $signed({2'b00, sp_q}) + offs_ext;
    high_s     = $signed({2'b00, HIGH_BOUND});
    low_s      = $signed({2'b00, LOW_BOUND});
  end

  always_comb begin
    sp_next  = sp_q;
    // clrfn clears both flags; a rejection below re-sets its own flag,
    // so a same-edge set wins while the other flag is still cleared.
    ovf_next = clrfn ? ovf_q : 1'b0;
    unf_next = clrfn ? unf_q : 1'b0;

    if (!loadn) begin
      sp_next = abus;
    end else if (!addn) begin
      if (add_r > high_s) begin
        ovf_next = 1'b1;
      end else if (add_r < low_s) begin
        unf_next = 1'b1;
      end else begin
        sp_next = add_r[WIDTH-1:0];
      end
    end else if (!cupn && cdownn) begin
      if (up_sum > {1'b0, HIGH_BOUND}) begin
        ovf_next = 1'b1;
      end else begin
        sp_next = up_sum[WIDTH-1:0];
      end
    end else if (cupn && !cdownn) begin
      if ({1'b0, sp_q} < down_limit) begin
        unf_next = 1'b1;
      end else begin
        sp_next = sp_q - STEP_W[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= RESET_VALUE;
      out_q <= RESET_VALUE;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_next;
      // Captures the pre-edge pointer, so the bus lags sp by one cycle and
      // a load from our own driven bus never forms a combinational loop.
      out_q <= sp_q;
      ovf_q <= ovf_next;
      unf_q <= unf_next;
    end
  end

  assign abus = outn ? {WIDTH{1'bz}} : out_q;
  assign sp   = sp_q;
  assign ovf  = ovf_q;
  assign unf  = unf_q;

endmodule

// File: tb/tb_stack_pointer_p.sv
module tb_stack_pointer_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        loadn, addn, cupn, cdownn, clrfn;
  logic        outn_a, outn_b;
  logic        drv_en;
  logic [15:0] drv_val;
  wire  [15:0] abus_a, abus_b;
  logic [15:0] sp_a, sp_b;
  logic        ovf_a, unf_a, ovf_b, unf_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign abus_a = drv_en ? drv_val : 16'hzzzz;
  assign abus_b = drv_en ? drv_val : 16'hzzzz;

  // A: full range, STEP=2, reset value near the top.
  stack_pointer_p #(
    .WIDTH(16), .STEP(2), .OFFS_WIDTH(8), .RESET_VALUE(16'hFFFE),
    .LOW_BOUND(16'h0000), .HIGH_BOUND(16'hFFFF)
  ) u_a (
    .clk(clk), .reset(reset), .loadn(loadn), .addn(addn), .cupn(cupn),
    .cdownn(cdownn), .clrfn(clrfn), .outn(outn_a), .abus(abus_a),
    .sp(sp_a), .ovf(ovf_a), .unf(unf_a)
  );

  // B: narrow window for bound checks, STEP=2.
  stack_pointer_p #(
    .WIDTH(16), .STEP(2), .OFFS_WIDTH(8), .RESET_VALUE(16'h0000),
    .LOW_BOUND(16'h0100), .HIGH_BOUND(16'h01FF)
  ) u_b (
    .clk(clk), .reset(reset), .loadn(loadn), .addn(addn), .cupn(cupn),
    .cdownn(cdownn), .clrfn(clrfn), .outn(outn_b), .abus(abus_b),
    .sp(sp_b), .ovf(ovf_b), .unf(unf_b)
  );

  typedef struct {
    logic        loadn;
    logic        addn;
    logic        cupn;
    logic        cdownn;
    logic        clrfn;
    logic        drv;
    logic [15:0] val;
    logic [15:0] exp_sp;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    loadn = 1'b1; addn = 1'b1; cupn = 1'b1; cdownn = 1'b1; clrfn = 1'b1;
    drv_en = 1'b0; drv_val = 16'h0000;
  endtask

  initial begin
    //            L     A     U     D     C     drv   val       sp        ovf   unf
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h01FD, 16'h01FD, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h01FF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h01FF, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h01FF, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h01FF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0102, 16'h0102, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0102, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00FE, 16'h0100, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h0100, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h007F, 16'h017F, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h007F, 16'h01FE, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 16'h01FE, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h0100, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h4000, 16'h4000, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 16'h4000, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b1};

    idle();
    outn_a = 1'b1; outn_b = 1'b1;
    reset = 1'b1;
    tick(); tick();

    // Reset state, bus released, then registered value driven.
    check("reset sp_a", 32'(sp_a), 32'h0000FFFE);
    check("reset ovf_a", 32'(ovf_a), 32'h0);
    check("reset unf_a", 32'(unf_a), 32'h0);
    drv_en = 1'b1; drv_val = 16'h0000; #1;
    check("abus_a released", 32'(abus_a), 32'h00000000);
    drv_en = 1'b0; outn_a = 1'b0; #1;
    check("abus_a driven after reset", 32'(abus_a), 32'h0000FFFE);
    outn_a = 1'b1;

    // Top of the full range: 0xFFFE + 2 is rejected, no wrap.
    reset = 1'b0; cupn = 1'b0;
    tick();
    check("top step sp_a", 32'(sp_a), 32'h0000FFFE);
    check("top step ovf_a", 32'(ovf_a), 32'h1);
    idle();

    // Load then count down; bus lags sp by one cycle.
    drv_en = 1'b1; drv_val = 16'h1234; loadn = 1'b0;
    tick();
    check("load sp_a", 32'(sp_a), 32'h00001234);
    idle(); outn_a = 1'b0; cdownn = 1'b0;
    tick();
    check("down1 sp_a", 32'(sp_a), 32'h00001232);
    check("down1 abus_a", 32'(abus_a), 32'h00001234);
    tick();
    check("down2 sp_a", 32'(sp_a), 32'h00001230);
    check("down2 abus_a", 32'(abus_a), 32'h00001232);
    tick();
    check("down3 sp_a", 32'(sp_a), 32'h0000122E);
    check("down3 abus_a", 32'(abus_a), 32'h00001230);

    // Load from our own driven bus picks up the registered value.
    cdownn = 1'b1; loadn = 1'b0;
    tick();
    check("self load sp_a", 32'(sp_a), 32'h00001230);
    check("self load abus_a", 32'(abus_a), 32'h0000122E);
    idle(); outn_a = 1'b1;

    // Signed add; upper bus bits are ignored for the offset.
    drv_en = 1'b1; drv_val = 16'h2000; loadn = 1'b0;
    tick();
    loadn = 1'b1; addn = 1'b0; drv_val = 16'hABF0;
    tick();
    check("add -16 sp_a", 32'(sp_a), 32'h00001FF0);
    drv_val = 16'h007F;
    tick();
    check("add +127 sp_a", 32'(sp_a), 32'h0000206F);
    check("add ovf_a", 32'(ovf_a), 32'h1);
    idle();

    // Clean start for the bounded instance.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset sp_b", 32'(sp_b), 32'h00000000);

    for (int i = 0; i < 22; i++) begin
      loadn  = vecs[i].loadn;
      addn   = vecs[i].addn;
      cupn   = vecs[i].cupn;
      cdownn = vecs[i].cdownn;
      clrfn  = vecs[i].clrfn;
      drv_en = vecs[i].drv;
      drv_val = vecs[i].val;
      tick();
      check($sformatf("vec%0d sp_b", i), 32'(sp_b), 32'(vecs[i].exp_sp));
      check($sformatf("vec%0d ovf_b", i), 32'(ovf_b), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d unf_b", i), 32'(unf_b), 32'(vecs[i].exp_unf));
    end
    idle();

    // Reset while counting up overrides the command, counting resumes after.
    reset = 1'b1;
    tick();
    reset = 1'b0; cupn = 1'b0;
    tick();
    check("count pre-reset sp_b", 32'(sp_b), 32'h00000002);
    reset = 1'b1;
    tick();
    check("mid reset sp_b", 32'(sp_b), 32'h00000000);
    reset = 1'b0;
    tick();
    check("resume1 sp_b", 32'(sp_b), 32'h00000002);
    tick();
    check("resume2 sp_b", 32'(sp_b), 32'h00000004);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
